// File: rtl/present_enc_ctrl_pkg.sv
// Shared types, widths and the PRESENT 4-bit S-box for the PRESENT-80 encryption controller.
package present_pkg;

    localparam int unsigned STATE_W = 64;
    localparam int unsigned KEY_W   = 80;
    localparam int unsigned CNT_W   = 5;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] v);
        return SBOX[v];
    endfunction

endpackage

// File: rtl/present_key_update.sv
// PRESENT-80 key schedule step: rotate left 61, S-box the top nibble, XOR counter into bits 19:15.
module present_key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] k,
    input  logic [CNT_W-1:0] i,
    output logic [KEY_W-1:0] k_next
);

    logic [KEY_W-1:0] rot;

    always_comb begin
        rot            = {k[18:0], k[79:19]};
        k_next         = rot;
        k_next[79:76]  = sbox(rot[79:76]);
        k_next[19:15]  = rot[19:15] ^ i;
    end

endmodule

// File: rtl/round.sv
// One combinational PRESENT round: add round key (k[79:16]), S-layer, then P-layer.
module round
    import present_pkg::*;
(
    input  logic [STATE_W-1:0] x,
    input  logic [KEY_W-1:0]   k,
    output logic [STATE_W-1:0] r
);

    logic [STATE_W-1:0] t;
    logic [STATE_W-1:0] sl;
    logic               unused_k;

    assign unused_k = ^k[15:0];

    always_comb begin
        t  = x ^ k[79:16];
        sl = '0;
        for (int unsigned n = 0; n < 16; n++) begin
            sl[4*n +: 4] = sbox(t[4*n +: 4]);
        end
        // Bit b moves to 16*b mod 63; bit 63 is fixed.
        r = '0;
        for (int unsigned b = 0; b < 63; b++) begin
            r[(b*16) % 63] = sl[b];
        end
        r[63] = sl[63];
    end

endmodule

// File: rtl/present_enc_ctrl.sv
// Iterative PRESENT-80 encryption controller with 4-phase req/ack handshake.
// Optional: PRESENT_ENC_CTRL_ZEROISE_EN clears s, kr and r on the DONE->IDLE transition.
module present_enc_ctrl
    import present_pkg::*;
#(
    parameter int unsigned ROUNDS = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [STATE_W-1:0]  x,
    input  logic [KEY_W-1:0]    k,
    output logic                busy,
    output logic                ack,
    output logic [STATE_W-1:0]  r
);

    state_e             state_q, state_d;
    logic [STATE_W-1:0] s_q, s_d;
    logic [KEY_W-1:0]   kr_q, kr_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic [STATE_W-1:0] r_q, r_d;

    logic [STATE_W-1:0] round_out;
    logic [KEY_W-1:0]   kupd_out;

    round u_round (
        .x (s_q),
        .k (kr_q),
        .r (round_out)
    );

    present_key_update u_key_update (
        .k      (kr_q),
        .i      (i_q),
        .k_next (kupd_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            kr_q    <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            kr_q    <= kr_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        kr_d    = kr_q;
        i_d     = i_q;
        busy_d  = busy_q;
        ack_d   = ack_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    s_d     = x;
                    kr_d    = k;
                    i_d     = CNT_W'(1);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d  = round_out;
                kr_d = kupd_out;
                i_d  = i_q + CNT_W'(1);
                // Last round: fold in the whitening key produced by this same step.
                if (i_q == CNT_W'(ROUNDS)) begin
                    r_d     = round_out ^ kupd_out[79:16];
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
`ifdef PRESENT_ENC_CTRL_ZEROISE_EN
                    s_d     = '0;
                    kr_d    = '0;
                    r_d     = '0;
`else
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign ack  = ack_q;
    assign r    = r_q;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Self-checking bench for present_enc_ctrl: cycle-level handshake model plus directed known-answer vectors.
module tb_present_enc_ctrl;

    localparam int unsigned ROUNDS = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [63:0] x   = '0;
    logic [79:0] k   = '0;
    logic        busy;
    logic        ack;
    logic [63:0] r;

    int tests = 0;
    int fails = 0;

    present_enc_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .x    (x),
        .k    (k),
        .busy (busy),
        .ack  (ack),
        .r    (r)
    );

    always #5 clk = ~clk;

    // Textbook PRESENT-80: build all round keys first, then apply the rounds.
    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [3:0]  sb [16];
        logic [63:0] rk [32];
        logic [79:0] kreg;
        logic [63:0] st;
        logic [63:0] tmp;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        kreg = key;
        for (int n = 1; n <= ROUNDS + 1; n++) begin
            rk[n-1] = kreg[79:16];
            kreg = (kreg << 61) | (kreg >> 19);
            kreg[79:76] = sb[kreg[79:76]];
            kreg[19:15] = kreg[19:15] ^ 5'(n);
        end
        st = pt;
        for (int n = 1; n <= ROUNDS; n++) begin
            st = st ^ rk[n-1];
            for (int j = 0; j < 16; j++) st[4*j +: 4] = sb[st[4*j +: 4]];
            // Gather form: destination j takes source 4*j mod 63.
            for (int j = 0; j < 63; j++) tmp[j] = st[(4*j) % 63];
            tmp[63] = st[63];
            st = tmp;
        end
        return st ^ rk[ROUNDS];
    endfunction

    // Handshake model: rounds remaining, ack flag and expected result.
    int          m_left = 0;
    logic        m_ack  = 1'b0;
    logic [63:0] m_r    = '0;
    logic [63:0] m_x    = '0;
    logic [79:0] m_k    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_ack  <= 1'b0;
            m_r    <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_r   <= present80(m_x, m_k);
                m_ack <= 1'b1;
            end
        end else if (m_ack) begin
            if (!req) begin
                m_ack <= 1'b0;
`ifdef PRESENT_ENC_CTRL_ZEROISE_EN
                m_r   <= '0;
`endif
            end
        end else if (req) begin
            m_x    <= x;
            m_k    <= k;
            m_left <= ROUNDS;
        end
    end

    always @(negedge clk) begin
        tests++;
        if (busy !== (m_left > 0) || ack !== m_ack || r !== m_r) begin
            fails++;
            $display("FAIL cycle_model t=%0t busy=%b exp=%b ack=%b exp=%b r=%h exp=%h",
                     $time, busy, (m_left > 0), ack, m_ack, r, m_r);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one request, check latency, busy span, result and ack width.
    task automatic do_req(input logic [63:0] xv, input logic [79:0] kv, input bit pulse,
                          input logic [63:0] exp_r, input string nm);
        int n;
        int nb;
        int na;
        bit got;
        @(negedge clk);
        x = xv; k = kv; req = 1'b1;
        n = 0; nb = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (pulse) req = 1'b0;
            if (ack) got = 1'b1;
            else if (busy) nb++;
        end
        chk({nm, "_ack_seen"}, 64'(got), 64'd1);
        chk({nm, "_latency"}, 64'(n), 64'(ROUNDS + 1));
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(ROUNDS));
        chk({nm, "_r"}, r, exp_r);
        req = 1'b0;
        na = 1;
        repeat (3) begin
            @(negedge clk);
            if (ack) na++;
        end
        chk({nm, "_ack_width"}, 64'(na), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_r", r, 64'h0);
        #2 rst = 1'b0;

        do_req(64'h0, 80'h0, 1'b0, 64'h5579C1387B228445, "kat_zero");
        do_req(64'h0, {80{1'b1}}, 1'b0, 64'hE72C46C0F5945049, "kat_k1");
        do_req({64{1'b1}}, 80'h0, 1'b0, 64'hA112FFC72F68417B, "kat_x1");
        do_req({64{1'b1}}, {80{1'b1}}, 1'b1, 64'h3333DCD3213210D2, "kat_pulse");

        // Disturb inputs during RUN, then reset at cycle 15.
        @(negedge clk);
        x = 64'h0; k = 80'h0; req = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            x = {$urandom, $urandom};
            k = {16'($urandom), $urandom, $urandom};
            req = n[0];
        end
        chk("midrun_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_r", r, 64'h0);
        req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        do_req(64'h0, 80'h0, 1'b0, 64'h5579C1387B228445, "after_rst");

        // Hold req through DONE: no second acceptance until req drops.
        @(negedge clk);
        x = {64{1'b1}}; k = 80'h0; req = 1'b1;
        for (int n = 0; n < 100 && !ack; n++) @(negedge clk);
        chk("b2b_ack", 64'(ack), 64'd1);
        x = 64'h0123456789ABCDEF; k = {80{1'b1}};
        repeat (5) begin
            @(negedge clk);
            chk("b2b_hold_ack", 64'(ack), 64'd1);
            chk("b2b_hold_busy", 64'(busy), 64'd0);
        end
        chk("b2b_hold_r", r, 64'hA112FFC72F68417B);
        req = 1'b0;
        @(negedge clk);
        chk("b2b_ack_fall", 64'(ack), 64'd0);
`ifdef PRESENT_ENC_CTRL_ZEROISE_EN
        chk("b2b_r_after", r, 64'h0);
`else
        chk("b2b_r_after", r, 64'hA112FFC72F68417B);
`endif
        repeat (2) @(negedge clk);
        chk("b2b_idle_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
